// File: rtl/qvga_chroma_compositor_if.sv
// qvga_chroma_compositor_if: frame-buffer RAM and background ROM read bus
//   master (compositor): d_en, rAddr, bg_bank, bg_addr out; rData, bg_data in
//   slave  (memories):   the reverse
//   Both memories are synchronous with a read latency of exactly one clock.
interface qvga_chroma_compositor_if #(
  parameter int BANK_W = 2
);
  logic              d_en;
  logic [16:0]       rAddr;
  logic [15:0]       rData;
  logic [BANK_W-1:0] bg_bank;
  logic [14:0]       bg_addr;
  logic [15:0]       bg_data;
  modport master (output d_en, rAddr, bg_bank, bg_addr, input rData, bg_data);
  modport slave  (input d_en, rAddr, bg_bank, bg_addr, output rData, bg_data);
endinterface

// File: rtl/qvga_chroma_compositor.sv
// qvga_chroma_compositor: frame-buffer reader and chroma-key compositor, 2-cycle pipeline
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   x_pixel, y_pixel, DE  display coordinates and enable from the VGA timing controller
//   frame_start           blanking pulse; latches upscale, key_en and bg_sel
//   rclk                  memory clock (copy of clk)
//   mem                   frame-buffer / background-ROM read bus (master side)
//   camera_pixel          RGB444 result, pix_valid marks in-window DE pixels
//   key_count             keyed pixels in the previous frame (only with CHROMA_KEY_STATS_EN)
module qvga_chroma_compositor #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int BG_W       = 160,
  parameter int BG_H       = 120,
  parameter int KEY_MARGIN = 2,
  parameter int BANK_W     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [9:0]               x_pixel,
  input  logic [9:0]               y_pixel,
  input  logic                     DE,
  input  logic                     frame_start,
  input  logic                     upscale,
  input  logic                     key_en,
  input  logic [BANK_W-1:0]        bg_sel,
  output logic                     rclk,
  qvga_chroma_compositor_if.master mem,
  output logic [11:0]              camera_pixel,
  output logic                     pix_valid
`ifdef CHROMA_KEY_STATS_EN
  ,
  output logic [16:0]              key_count
`endif
);
  logic              upscale_q, key_en_q, v1_q, valid_q, win, keyed;
  logic [BANK_W-1:0] bg_bank_q;
  logic [9:0]        fx, fy, bx, by;
  logic [3:0]        r, g, b;
  logic [11:0]       pix_d, pix_q;
  logic              unused_ok;
  assign rclk = clk;
  // The background is half the source resolution, so it is always sampled one shift coarser.
  always_comb begin
    win = upscale_q ? ({1'b0, x_pixel} < 11'(H_ACT) && {1'b0, y_pixel} < 11'(V_ACT))
                    : ({1'b0, x_pixel} < 11'(SRC_W) && {1'b0, y_pixel} < 11'(SRC_H));
    fx  = upscale_q ? x_pixel >> 1 : x_pixel;
    fy  = upscale_q ? y_pixel >> 1 : y_pixel;
    bx  = upscale_q ? x_pixel >> 2 : x_pixel >> 1;
    by  = upscale_q ? y_pixel >> 2 : y_pixel >> 1;
  end
  assign mem.d_en    = win & DE;
  assign mem.rAddr   = win ? 17'(fy) * 17'(SRC_W) + 17'(fx) : '0;
  assign mem.bg_addr = win ? 15'(by) * 15'(BG_W) + 15'(bx) : '0;
  assign mem.bg_bank = bg_bank_q;
  assign r = mem.rData[15:12];
  assign g = mem.rData[10:7];
  assign b = mem.rData[4:1];
  // 5-bit compares so that R or B near 15 plus the margin cannot wrap and fake a key.
  assign keyed = key_en_q && ({1'b0, g} > {1'b0, r} + 5'(KEY_MARGIN))
                          && ({1'b0, g} > {1'b0, b} + 5'(KEY_MARGIN));
  assign pix_d = keyed ? {mem.bg_data[15:12], mem.bg_data[10:7], mem.bg_data[4:1]}
               : v1_q  ? {r, g, b} : 12'h000;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upscale_q <= 1'b0;
      key_en_q  <= 1'b0;
      bg_bank_q <= '0;
      v1_q      <= 1'b0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        upscale_q <= upscale;
        key_en_q  <= key_en;
        bg_bank_q <= bg_sel;
      end
      v1_q    <= DE && win;
      pix_q   <= pix_d;
      valid_q <= v1_q;
    end
  end
  assign camera_pixel = pix_q;
  assign pix_valid    = valid_q;
`ifdef CHROMA_KEY_STATS_EN
  logic [16:0] cnt_q, cnt_d, key_count_q;
  // A keyed pixel on the frame_start cycle opens the new frame's count.
  assign cnt_d = frame_start ? {16'd0, keyed} : cnt_q + {16'd0, keyed && cnt_q != 17'h1FFFF};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      key_count_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (frame_start) key_count_q <= cnt_q;
    end
  end
  assign key_count = key_count_q;
`endif
  assign unused_ok = ^{mem.rData[11], mem.rData[6:5], mem.rData[0], mem.bg_data[11],
                       mem.bg_data[6:5], mem.bg_data[0], mem.d_en, 1'(BG_H)};
endmodule
